gate_check_seq: RTL
===================

Name: gate_check_seq

Overview:
Self-checking sequencer for a 2-input combinational gate under test (default: the team's NOR gate).
- On a start pulse it drives operands a,b through all four vectors 00,01,10,11, waits a settle interval on each, and samples the gate output.
- It compares each sample against a parameterised truth table and reports pass/fail, a per-vector mismatch map and an error count.
- It replaces delay-driven stimulus with clocked, synthesizable bring-up and BIST of gate-level cells.

Parameters:
SETTLE_CYC, 3, cycles a/b are held before y is sampled; legal range 1..255.
TRUTH_TT, 4'b0001, expected y per vector; bit index = {a,b} (NOR default).
CNT_W, 8, width of the settle down-counter; must hold SETTLE_CYC-1.

Ports:
clk  in  1  single system clock, rising-edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  run request; sampled only in IDLE.
gate_a  out  1  operand a to the gate under test (registered).
gate_b  out  1  operand b to the gate under test (registered).
gate_y  in  1  gate output, combinational from gate_a/gate_b.
busy  out  1  high in SETTLE and SAMPLE.
done  out  1  one-cycle pulse when the run completes.
pass  out  1  1 when the last run had zero mismatches; held until the next accepted start.
err_cnt  out  3  number of mismatching vectors in the last run (0..4).
fail_vec  out  4  sticky mismatch map; bit idx set when y != TRUTH_TT[idx].
vec_idx  out  2  current vector index {a,b}.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state=IDLE.
  - gate_a, gate_b, busy, done, pass all 0.
  - err_cnt=0, fail_vec=0, vec_idx=0, counter=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: on start=1 (cycle 0):
  - clear err_cnt, fail_vec and pass.
  - vec_idx=0, {gate_a,gate_b}=00, counter=SETTLE_CYC-1.
  - go to SETTLE.
- SETTLE: when counter==0 go to SAMPLE, otherwise decrement. Occupies exactly SETTLE_CYC cycles.
- SAMPLE (1 cycle): compare gate_y with TRUTH_TT[vec_idx]. On mismatch, set fail_vec[vec_idx] and increment err_cnt.
  - If vec_idx==3: go to DONE.
  - Otherwise: vec_idx+1, load {gate_a,gate_b}=vec_idx+1, reload counter, go to SETTLE.
- Result registers: err_cnt and fail_vec are updated in the same cycle as the final SAMPLE.
- DONE (1 cycle): done=1, pass=(err_cnt==0), busy=0. Then go to IDLE.
- Operand hold: gate_a/gate_b are held at the last vector (11) after completion until the next start or reset.
- Per-vector timing: operands are stable for SETTLE_CYC+1 cycles per vector.
- Latency: done is asserted in cycle 1+4*(SETTLE_CYC+1) after the start cycle (cycle 17 for the default).
- start during SETTLE, SAMPLE or DONE is ignored (no queueing); a start coincident with done is dropped.
- Reset mid-run aborts immediately: all outputs return to reset values and the partial results are discarded.
- err_cnt cannot overflow (maximum 4 fits in 3 bits).

Decomposition:
- Package gate_check_pkg holds:
  - the state enum (IDLE/SETTLE/SAMPLE/DONE);
  - NUM_VEC=4;
  - truth-table constants TT_NOR=4'b0001, TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110.
- One natural sub-module: settle_timer, a loadable CNT_W down-counter with load, enable and zero flag.
- FSM, compare logic and result registers stay in gate_check_seq.

Test Plan:
1. Correct NOR DUT, SETTLE_CYC=3, start at cycle 0 -> busy for cycles 1..16, done pulse at cycle 17, pass=1, err_cnt=0, fail_vec=4'b0000, operands step 00,01,10,11 every 4 cycles.
2. AND gate connected, TRUTH_TT=4'b0001 -> done at cycle 17, pass=0, err_cnt=2, fail_vec=4'b1001.
3. gate_y tied to 1 -> err_cnt=3, fail_vec=4'b1110, pass=0. Follow with a correct DUT and a second start -> results clear, then pass=1.
4. start pulsed at cycles 5 and 17 of a run -> both ignored, exactly one done pulse, the next run begins only on a start in IDLE.
5. rst_n low while vec_idx=2 -> gate_a=gate_b=0, busy=0, fail_vec=0 asynchronously. A new start after release sequences from vector 00 and finishes with done at +17 cycles.
6. SETTLE_CYC=1 -> done at cycle 9, each vector held for 2 cycles, results identical to scenario 1.

Source files
------------

// File: rtl/gate_check_pkg.sv
// Shared types and constants for the gate check sequencer.
package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_VEC = 4;

  // Truth tables are indexed by {a,b}.
  localparam logic [3:0] TT_NOR = 4'b0001;
  localparam logic [3:0] TT_AND = 4'b1000;
  localparam logic [3:0] TT_OR  = 4'b1110;
  localparam logic [3:0] TT_XOR = 4'b0110;

endpackage

// File: rtl/gate_check_seq_timer.sv
// Loadable down-counter that measures the operand settle interval.
module settle_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/gate_check_seq.sv
// Sequencer that walks a 2-input gate through all four input vectors and
// checks each sampled output against a truth table.
//
// state  | meaning
// IDLE   | waiting for start; results and operands held
// SETTLE | operands applied, timer running down
// SAMPLE | gate output compared against the truth table
// DONE   | one-cycle completion pulse
module gate_check_seq
  import gate_check_pkg::*;
#(
  parameter int         SETTLE_CYC = 3,
  parameter logic [3:0] TRUTH_TT   = TT_NOR,
  parameter int         CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [3:0] fail_vec,
  output logic [1:0] vec_idx
);

  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(SETTLE_CYC - 1);
  localparam logic [1:0]       LAST_VEC = 2'(NUM_VEC - 1);

  state_t     state, state_nxt;
  logic [1:0] ops, ops_nxt;
  logic [1:0] vec_nxt;
  logic [2:0] err_nxt;
  logic [3:0] fail_nxt;
  logic       pass_nxt;
  logic       tmr_load, tmr_en, tmr_zero;

  settle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (RELOAD),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ops      <= 2'b00;
      vec_idx  <= 2'd0;
      err_cnt  <= 3'd0;
      fail_vec <= 4'd0;
      pass     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ops      <= ops_nxt;
      vec_idx  <= vec_nxt;
      err_cnt  <= err_nxt;
      fail_vec <= fail_nxt;
      pass     <= pass_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ops_nxt   = ops;
    vec_nxt   = vec_idx;
    err_nxt   = err_cnt;
    fail_nxt  = fail_vec;
    pass_nxt  = pass;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          err_nxt   = 3'd0;
          fail_nxt  = 4'd0;
          pass_nxt  = 1'b0;
          vec_nxt   = 2'd0;
          ops_nxt   = 2'b00;
          tmr_load  = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (tmr_zero) state_nxt = SAMPLE;
        else          tmr_en    = 1'b1;
      end
      SAMPLE: begin
        if (gate_y != TRUTH_TT[vec_idx]) begin
          fail_nxt[vec_idx] = 1'b1;
          err_nxt           = err_cnt + 3'd1;
        end
        // pass is resolved here so it is already valid during the done pulse
        if (vec_idx == LAST_VEC) begin
          pass_nxt  = (err_nxt == 3'd0);
          state_nxt = DONE;
        end else begin
          vec_nxt   = vec_idx + 2'd1;
          ops_nxt   = vec_idx + 2'd1;
          tmr_load  = 1'b1;
          state_nxt = SETTLE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign gate_a = ops[1];
  assign gate_b = ops[0];
  assign busy   = (state == SETTLE) || (state == SAMPLE);
  assign done   = (state == DONE);

endmodule
